// File: rtl/memory_pkg.sv
// Shared definitions for the 1R1W write-first memory.
//   init_state_e : init sequencer states (INIT while zeroing the array, READY after)
//   MEM_DEPTH / MEM_WIDTH : default geometry
//   byte_parity  : even parity of one byte (used when MEMORY_1R1W_PARITY_EN is defined)
package memory_pkg;

    localparam int MEM_DEPTH = 32;
    localparam int MEM_WIDTH = 64;

    typedef enum logic {INIT, READY} init_state_e;

    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/memory_init_seq.sv
// Post-reset init sequencer: walks every address once, requesting an all-zero
// write, then parks in READY until the next reset.
//   clock     : rising-edge clock
//   reset     : async active-low reset, restarts the walk from address 0
//   busy      : high while the walk is in progress (DEPTH cycles)
//   init_we   : init write strobe
//   init_addr : address being zeroed this cycle
module memory_init_seq
    import memory_pkg::*;
#(
    parameter int DEPTH  = MEM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              busy,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    init_state_e       state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= INIT;
            cnt   <= '0;
        end else if (state == INIT) begin
            // The write to LAST happens on this edge; READY takes over after it.
            if (cnt == LAST) state <= READY;
            else             cnt   <= cnt + ADDR_W'(1);
        end
    end

    assign busy      = (state == INIT);
    assign init_we   = busy;
    assign init_addr = cnt;

endmodule

// File: rtl/memory_1r1w_write_first.sv
// Synchronous 1R1W memory, one-cycle registered read, write-first forwarding.
// The array is zeroed by memory_init_seq after every reset; requests are
// ignored while busy. Out-of-range writes are dropped, out-of-range reads
// return zero.
// Optional: `define MEMORY_1R1W_PARITY_EN stores one even-parity bit per byte
// and raises rerr (with rvalid) when a stored byte fails its parity check.
//   clock, reset                : clock, async active-low reset
//   ren, raddr                  : read request
//   rvalid, rdata, rerr         : read response, one cycle after request
//   wen, waddr, wdata, wmask    : byte-masked write request
//   busy                        : init walk in progress
module memory_1r1w_write_first
    import memory_pkg::*;
#(
    parameter int DEPTH  = MEM_DEPTH,
    parameter int WIDTH  = MEM_WIDTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ren,
    input  logic [ADDR_W-1:0]    raddr,
    output logic                 rvalid,
    output logic [WIDTH-1:0]     rdata,
    output logic                 rerr,
    input  logic                 wen,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [WIDTH/8-1:0]   wmask,
    output logic                 busy
);

    localparam int NB = WIDTH / 8;
    // One extra bit so DEPTH itself is representable (e.g. DEPTH=32, ADDR_W=5).
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;

    memory_init_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_init (
        .clock     (clock),
        .reset     (reset),
        .busy      (busy),
        .init_we   (init_we),
        .init_addr (init_addr)
    );

    logic rd_ok, wr_ok, rd_act, wr_act, fwd_hit;
    assign rd_ok   = ({1'b0, raddr} < DEPTH_C);
    assign wr_ok   = ({1'b0, waddr} < DEPTH_C);
    assign rd_act  = !busy && ren;
    assign wr_act  = !busy && wen && wr_ok;
    // wr_act implies waddr in range, so a hit also implies raddr in range.
    assign fwd_hit = wr_act && (waddr == raddr);

    logic [WIDTH-1:0] rd_word, rd_next;
    logic [NB-1:0]    fwd_byte;

    always_comb begin
        rd_word = rd_ok ? mem[raddr] : '0;
        for (int i = 0; i < NB; i++) begin
            fwd_byte[i]        = fwd_hit && wmask[i];
            rd_next[i*8 +: 8]  = fwd_byte[i] ? wdata[i*8 +: 8] : rd_word[i*8 +: 8];
        end
    end

`ifdef MEMORY_1R1W_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic [NB-1:0] rd_par;
    logic          rerr_next;

    always_comb begin
        rd_par    = rd_ok ? par[raddr] : '0;
        rerr_next = 1'b0;
        // Forwarded bytes never come from the array, so they cannot be corrupt.
        for (int i = 0; i < NB; i++)
            if (!fwd_byte[i] && (byte_parity(rd_word[i*8 +: 8]) != rd_par[i]))
                rerr_next = 1'b1;
    end
`endif

    // Array (and parity) storage: no reset, contents are defined by the init walk.
    always_ff @(posedge clock) begin
        if (init_we) begin
            mem[init_addr] <= '0;
`ifdef MEMORY_1R1W_PARITY_EN
            par[init_addr] <= '0;
`endif
        end else if (wr_act) begin
            for (int i = 0; i < NB; i++)
                if (wmask[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
`ifdef MEMORY_1R1W_PARITY_EN
                    par[waddr][i]        <= byte_parity(wdata[i*8 +: 8]);
`endif
                end
        end
    end

    // Read register: rdata/rerr hold when no read is accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= rd_act;
            if (rd_act) rdata <= rd_next;
        end
    end

`ifdef MEMORY_1R1W_PARITY_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      rerr <= 1'b0;
        else if (rd_act) rerr <= rerr_next;
    end
`else
    assign rerr = 1'b0;
`endif

endmodule

// File: tb/tb_memory_1r1w_write_first.sv
// Randomized self-checking bench for memory_1r1w_write_first: a 32-word
// instance and a 20-word instance (for out-of-range addressing), both
// compared against plain array models.
module tb_memory_1r1w_write_first;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    // DEPTH=32 instance
    logic        ren, wen, rvalid, rerr, busy;
    logic [4:0]  raddr, waddr;
    logic [63:0] wdata, rdata;
    logic [7:0]  wmask;
    // DEPTH=20 instance
    logic        b_ren, b_wen, b_rvalid, b_rerr, b_busy;
    logic [4:0]  b_raddr, b_waddr;
    logic [63:0] b_wdata, b_rdata;
    logic [7:0]  b_wmask;

    memory_1r1w_write_first dut (
        .clock(clock), .reset(reset),
        .ren(ren), .raddr(raddr), .rvalid(rvalid), .rdata(rdata), .rerr(rerr),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wmask(wmask), .busy(busy)
    );

    memory_1r1w_write_first #(.DEPTH(20)) dut20 (
        .clock(clock), .reset(reset),
        .ren(b_ren), .raddr(b_raddr), .rvalid(b_rvalid), .rdata(b_rdata), .rerr(b_rerr),
        .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata), .wmask(b_wmask), .busy(b_busy)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [63:0] model   [32];
    logic [63:0] model20 [20];
    logic [63:0] last_rd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++)
            if (m[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        return r;
    endfunction

    task automatic idle;
        ren = 0; wen = 0; raddr = 0; waddr = 0; wdata = 0; wmask = 0;
        b_ren = 0; b_wen = 0; b_raddr = 0; b_waddr = 0; b_wdata = 0; b_wmask = 0;
    endtask

    task automatic zero_models;
        for (int i = 0; i < 32; i++) model[i] = '0;
        for (int i = 0; i < 20; i++) model20[i] = '0;
        last_rd = '0;
    endtask

    // Counts busy cycles of both instances from the current sample onward;
    // rvalid must stay low throughout, whatever requests are being driven.
    task automatic wait_init(output int c32, output int c20);
        c32 = 0;
        c20 = 0;
        for (int k = 0; k < 100; k++) begin
            if (!busy && !b_busy) break;
            if (busy)   c32++;
            if (b_busy) c20++;
            chk("busy_rvalid", {63'd0, rvalid}, 64'd0);
            tick;
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [63:0] d, input logic [7:0] m);
        wen = 1; waddr = a; wdata = d; wmask = m;
        tick;
        wen = 0;
        model[a] = merge(model[a], d, m);
    endtask

    task automatic do_read(input string tag, input logic [4:0] a);
        ren = 1; raddr = a;
        tick;
        ren = 0;
        last_rd = model[a];
        chk({tag, "_vld"}, {63'd0, rvalid}, 64'd1);
        chk(tag, rdata, last_rd);
        chk({tag, "_err"}, {63'd0, rerr}, 64'd0);
    endtask

    task automatic b_read(input string tag, input logic [4:0] a, input logic [63:0] exp);
        b_ren = 1; b_raddr = a;
        tick;
        b_ren = 0;
        chk({tag, "_vld"}, {63'd0, b_rvalid}, 64'd1);
        chk(tag, b_rdata, exp);
        chk({tag, "_err"}, {63'd0, b_rerr}, 64'd0);
    endtask

    initial begin
        int c32, c20;
        logic [63:0] exp, d;
        logic [4:0]  ra, wa;
        logic [7:0]  wm;
        logic        re, we;

        reset = 0;
        idle;
        zero_models;
        tick; tick;
        chk("rst_busy",   {63'd0, busy},   64'd1);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_rdata",  rdata,           64'd0);
        chk("rst_rerr",   {63'd0, rerr},   64'd0);
        chk("rst_busy20", {63'd0, b_busy}, 64'd1);

        reset = 1;
        wait_init(c32, c20);
        chk("busy_len",   64'(c32), 64'd32);
        chk("busy_len20", 64'(c20), 64'd20);

        for (int a = 0; a < 32; a++) do_read("init_rd", 5'(a));

        do_write(5, 64'h0123456789ABCDEF, 8'hFF);
        do_read("wr_rd5", 5);

        // Same-cycle forwarding with partial mask
        do_write(7, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        ren = 1; raddr = 7; wen = 1; waddr = 7; wdata = 64'h1111111111111111; wmask = 8'h0F;
        tick;
        idle;
        last_rd = 64'hFFFFFFFF11111111;
        chk("fwd_vld", {63'd0, rvalid}, 64'd1);
        chk("fwd7", rdata, last_rd);
        model[7] = merge(model[7], 64'h1111111111111111, 8'h0F);
        do_read("fwd7_after", 7);

        // Random mixed traffic
        for (int n = 0; n < 400; n++) begin
            re = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            ra = 5'($urandom_range(0, 31));
            wa = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            wm = 8'($urandom);
            d  = {$urandom, $urandom};
            ren = re; raddr = ra; wen = we; waddr = wa; wdata = d; wmask = wm;
            exp = model[ra];
            if (we && wa == ra) exp = merge(exp, d, wm);
            tick;
            if (re) last_rd = exp;
            if (we) model[wa] = merge(model[wa], d, wm);
            chk("rnd_vld", {63'd0, rvalid}, {63'd0, re});
            chk("rnd_data", rdata, last_rd);
            chk("rnd_err", {63'd0, rerr}, 64'd0);
        end
        idle;

        // Reset mid-init, with requests held during the whole second walk
        reset = 0; tick; reset = 1;
        for (int k = 0; k < 10; k++) tick;
        reset = 0; tick;
        ren = 1; raddr = 0; wen = 1; waddr = 0; wdata = '1; wmask = 8'hFF;
        b_wen = 1; b_waddr = 0; b_wdata = '1; b_wmask = 8'hFF;
        reset = 1;
        wait_init(c32, c20);
        idle;
        zero_models;
        chk("rst2_busy_len",   64'(c32), 64'd32);
        chk("rst2_busy_len20", 64'(c20), 64'd20);
        for (int a = 0; a < 32; a++) do_read("rst2_rd", 5'(a));

        // DEPTH=20: out-of-range write dropped, out-of-range read returns 0
        for (int a = 0; a < 20; a++) begin
            d = {$urandom, $urandom};
            b_wen = 1; b_waddr = 5'(a); b_wdata = d; b_wmask = 8'hFF;
            tick;
            model20[a] = d;
        end
        b_wen = 1; b_waddr = 25; b_wdata = '1; b_wmask = 8'hFF;
        tick;
        b_wen = 1; b_waddr = 31; b_ren = 1; b_raddr = 31;
        tick;
        b_wen = 0;
        chk("oor_fwd_vld", {63'd0, b_rvalid}, 64'd1);
        chk("oor_fwd", b_rdata, 64'd0);
        for (int a = 0; a < 20; a++) b_read("d20_rd", 5'(a), model20[a]);
        b_read("oor_rd25", 25, 64'd0);
        idle;

`ifdef MEMORY_1R1W_PARITY_EN
        do_write(3, {$urandom, $urandom}, 8'hFF);
        dut.mem[3][0] = ~dut.mem[3][0];
        model[3][0]   = ~model[3][0];
        ren = 1; raddr = 3;
        tick;
        ren = 0;
        chk("par_vld",  {63'd0, rvalid}, 64'd1);
        chk("par_data", rdata, model[3]);
        chk("par_err",  {63'd0, rerr}, 64'd1);
        d = {$urandom, $urandom};
        ren = 1; raddr = 3; wen = 1; waddr = 3; wdata = d; wmask = 8'h01;
        tick;
        idle;
        model[3] = merge(model[3], d, 8'h01);
        chk("par_fwd_data", rdata, model[3]);
        chk("par_fwd_err",  {63'd0, rerr}, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
